// File: rtl/ddr3_rd_pkg.sv
// ddr3_rd_pkg: shared types and constants for the DDR3 read-capture path.
//   BEATS / SCLK_BEATS : BL8 burst gathered over 4 SCLK cycles (Q0,Q1 per cycle)
//   ERR_*              : bit positions inside the sticky err vector
//   cap_state_t        : capture sequencer states
//   rd_word_t          : {data, tag} view of one completed burst at default widths
package ddr3_rd_pkg;

   localparam int BEATS         = 8;
   localparam int SCLK_BEATS    = 4;

   localparam int ERR_TAG_OVF   = 0;
   localparam int ERR_COLLISION = 1;
   localparam int ERR_OUT_OVF   = 2;
   localparam int ERR_W         = 3;

   localparam int WORD_DQ_W     = 16;
   localparam int WORD_TAG_W    = 4;

   typedef enum logic {
      IDLE = 1'b0,
      CAP  = 1'b1
   } cap_state_t;

   typedef struct packed {
      logic [BEATS*WORD_DQ_W-1:0] data;
      logic [WORD_TAG_W-1:0]      tag;
   } rd_word_t;

endpackage

// File: rtl/ddr3_rd_sync_fifo.sv
// ddr3_rd_sync_fifo: small synchronous FIFO, first-word-fall-through head.
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   push/data  : write request; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop        : remove head entry (ignored when empty)
//   head       : current head entry
//   empty/full : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module ddr3_rd_sync_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wp] <= push_data;
            wp      <= wp + 1'b1;
         end
         if (do_pop) begin
            rp <= rp + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ddr3_rd_capture_ctrl.sv
// ddr3_rd_capture_ctrl: read-path sequencer for the x1 input-DDR capture cells.
//   SCLK, RST          : sole clock, synchronous active-high reset
//   rd_issue, rd_tag   : READ command strobe and its tag
//   cfg_rl             : read latency (issue cycle to first beat), SCLK cycles
//   iddr_q0, iddr_q1   : capture-cell rising/falling samples, all DQ lanes
//   iddr_rst           : capture-cell reset, held 2 cycles past RST
//   out_valid/ready    : burst word handshake; out_data beat b at [b*DQ_WIDTH +: DQ_WIDTH]
//   out_tag            : tag of out_data
//   busy               : reads pending or capture in progress
//   err                : sticky {out_overflow, capture_collision, tag_fifo_overflow}
// Optional RD_LAT_CAL_EN adds cal_start / cal_done / cal_rl read-latency
// calibration against an MPR pattern (Q0 all zero, Q1 all ones).
module ddr3_rd_capture_ctrl
   import ddr3_rd_pkg::*;
#(
   parameter int DQ_WIDTH = 16,
   parameter int TAG_W    = 4,
   parameter int QDEPTH   = 4,
   parameter int RL_W     = 5
) (
   input  logic                      SCLK,
   input  logic                      RST,
   input  logic                      rd_issue,
   input  logic [TAG_W-1:0]          rd_tag,
   input  logic [RL_W-1:0]           cfg_rl,
   input  logic [DQ_WIDTH-1:0]       iddr_q0,
   input  logic [DQ_WIDTH-1:0]       iddr_q1,
   output logic                      iddr_rst,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BEATS*DQ_WIDTH-1:0] out_data,
   output logic [TAG_W-1:0]          out_tag,
   output logic                      busy,
   output logic [ERR_W-1:0]          err
`ifdef RD_LAT_CAL_EN
   ,
   input  logic                      cal_start,
   output logic                      cal_done,
   output logic [RL_W-1:0]           cal_rl
`endif
);

   localparam int DL_LEN = 1 << RL_W;
   localparam int WORD_W = BEATS * DQ_WIDTH;
   localparam int CNT_W  = $clog2(SCLK_BEATS);

   cap_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [WORD_W-1:0]   cap_word;
   logic [TAG_W-1:0]    cur_tag;
   logic [DL_LEN-1:0]   dl;
   logic [DL_LEN-1:0]   shifted;
   logic [RL_W-1:0]     rl_eff;
   logic [RL_W-1:0]     rl_use;
   logic [RL_W-1:0]     tap;
   logic [1:0]          rst_pipe;

   logic                issue_ok;
   logic                issue_acc;
   logic                tag_ovf;
   logic                start;
   logic                in_cap;
   logic                last;
   logic                collide;
   logic                accept;
   logic                bypass;
   logic [TAG_W-1:0]    start_tag;

   logic                tag_push;
   logic                tag_pop;
   logic [TAG_W-1:0]    tag_head;
   logic                tag_empty;
   logic                tag_full;

   logic [WORD_W-1:0]       done_word;
   logic                    out_push;
   logic                    out_pop;
   logic                    out_drop;
   logic [WORD_W+TAG_W-1:0] out_head;
   logic                    out_empty;
   logic                    out_full;

   // iddr_rst tracks RST, then trails its release by two cycles.
   always_ff @(posedge SCLK) begin
      if (RST) begin
         rst_pipe <= 2'b11;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b0};
      end
   end
   assign iddr_rst = rst_pipe[1];

   assign issue_ok  = rd_issue & ~iddr_rst;
   assign issue_acc = issue_ok & ~tag_full;
   assign tag_ovf   = issue_ok & tag_full;

   // Latency is only re-latched with nothing in flight.
   assign rl_use  = ((dl == '0) && (state == IDLE)) ? cfg_rl : rl_eff;
   assign tap     = (rl_use == '0) ? '0 : rl_use - 1'b1;
   assign shifted = {dl[DL_LEN-2:0], issue_acc};
   assign start   = shifted[tap];

   assign in_cap  = (state == CAP);
   assign last    = in_cap && (cnt == CNT_W'(SCLK_BEATS - 1));
   assign collide = start & in_cap & ~last;
   assign accept  = start & ~collide;

   // Each start pulse (accepted or colliding) consumes its own tag when the
   // pulse fires, which keeps tags aligned with bursts. With RL=1 the pulse
   // lands in the issue cycle, so the tag bypasses the empty FIFO.
   assign bypass    = start & tag_empty;
   assign start_tag = tag_empty ? rd_tag : tag_head;
   assign tag_push  = issue_acc & ~bypass;
   assign tag_pop   = start & ~tag_empty;

   ddr3_rd_sync_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (TAG_W)
   ) u_tag_fifo (
      .clk       (SCLK),
      .rst       (RST),
      .push      (tag_push),
      .push_data (rd_tag),
      .pop       (tag_pop),
      .head      (tag_head),
      .empty     (tag_empty),
      .full      (tag_full)
   );

   // Final beat pair is folded in combinationally on the completing cycle.
   assign done_word = {iddr_q1, iddr_q0, cap_word[6*DQ_WIDTH-1:0]};
   assign out_pop   = ~out_empty & out_ready;
   assign out_push  = last & (~out_full | out_pop);
   assign out_drop  = last & out_full & ~out_pop;

   ddr3_rd_sync_fifo #(
      .DEPTH (2),
      .WIDTH (WORD_W + TAG_W)
   ) u_out_fifo (
      .clk       (SCLK),
      .rst       (RST),
      .push      (out_push),
      .push_data ({done_word, cur_tag}),
      .pop       (out_pop),
      .head      (out_head),
      .empty     (out_empty),
      .full      (out_full)
   );

   assign out_valid = ~out_empty;
   assign out_data  = out_head[WORD_W+TAG_W-1:TAG_W];
   assign out_tag   = out_head[TAG_W-1:0];
   assign busy      = (|dl) | in_cap | ~tag_empty;

   always_ff @(posedge SCLK) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         cap_word <= '0;
         cur_tag  <= '0;
         dl       <= '0;
         rl_eff   <= '0;
         err      <= '0;
      end else begin
         dl     <= shifted;
         rl_eff <= rl_use;
         if (tag_ovf)  err[ERR_TAG_OVF]   <= 1'b1;
         if (collide)  err[ERR_COLLISION] <= 1'b1;
         if (out_drop) err[ERR_OUT_OVF]   <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= CAP;
                  cnt     <= '0;
                  cur_tag <= start_tag;
               end
            end
            CAP: begin
               cap_word[2*int'(cnt)*DQ_WIDTH +: DQ_WIDTH]     <= iddr_q0;
               cap_word[(2*int'(cnt)+1)*DQ_WIDTH +: DQ_WIDTH] <= iddr_q1;
               if (last) begin
                  cnt <= '0;
                  if (accept) begin
                     cur_tag <= start_tag;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RD_LAT_CAL_EN
   logic            cal_armed;
   logic            cal_run;
   logic [RL_W-1:0] cal_cnt;

   // cal_cnt holds the number of cycles elapsed since the arming rd_issue.
   always_ff @(posedge SCLK) begin
      if (RST) begin
         cal_armed <= 1'b0;
         cal_run   <= 1'b0;
         cal_cnt   <= '0;
         cal_done  <= 1'b0;
         cal_rl    <= '0;
      end else if (cal_start) begin
         cal_armed <= 1'b1;
         cal_run   <= 1'b0;
         cal_cnt   <= '0;
         cal_done  <= 1'b0;
         cal_rl    <= '0;
      end else if (cal_armed && !cal_run) begin
         if (issue_acc) begin
            cal_run <= 1'b1;
            cal_cnt <= RL_W'(1);
         end
      end else if (cal_run) begin
         if ((iddr_q0 == '0) && (iddr_q1 == '1)) begin
            cal_rl    <= cal_cnt;
            cal_done  <= 1'b1;
            cal_run   <= 1'b0;
            cal_armed <= 1'b0;
         end else if (cal_cnt == '1) begin
            cal_rl    <= '0;
            cal_done  <= 1'b1;
            cal_run   <= 1'b0;
            cal_armed <= 1'b0;
         end else begin
            cal_cnt <= cal_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ddr3_rd_capture_ctrl.sv
// tb_ddr3_rd_capture_ctrl: directed bench with a tag/word scoreboard.
// Stimulus pushes expected bursts into queues; a separate monitor pops and
// compares on every accepted output transfer.
module tb_ddr3_rd_capture_ctrl;
   import ddr3_rd_pkg::*;

   localparam int DQ  = 16;
   localparam int TW  = 4;
   localparam int QD  = 4;
   localparam int RLW = 5;

   logic            SCLK;
   logic            RST;
   logic            rd_issue;
   logic [TW-1:0]   rd_tag;
   logic [RLW-1:0]  cfg_rl;
   logic [DQ-1:0]   iddr_q0;
   logic [DQ-1:0]   iddr_q1;
   logic            iddr_rst;
   logic            out_valid;
   logic            out_ready;
   logic [8*DQ-1:0] out_data;
   logic [TW-1:0]   out_tag;
   logic            busy;
   logic [2:0]      err;
`ifdef RD_LAT_CAL_EN
   logic            cal_start;
   logic            cal_done;
   logic [RLW-1:0]  cal_rl;
`endif

   ddr3_rd_capture_ctrl #(
      .DQ_WIDTH (DQ),
      .TAG_W    (TW),
      .QDEPTH   (QD),
      .RL_W     (RLW)
   ) dut (
      .SCLK      (SCLK),
      .RST       (RST),
      .rd_issue  (rd_issue),
      .rd_tag    (rd_tag),
      .cfg_rl    (cfg_rl),
      .iddr_q0   (iddr_q0),
      .iddr_q1   (iddr_q1),
      .iddr_rst  (iddr_rst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy),
      .err       (err)
`ifdef RD_LAT_CAL_EN
      ,
      .cal_start (cal_start),
      .cal_done  (cal_done),
      .cal_rl    (cal_rl)
`endif
   );

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int base   = 0;
   int n      = 0;

   logic [8*DQ-1:0] exp_d [$];
   logic [TW-1:0]   exp_t [$];

   initial begin
      SCLK = 1'b0;
      forever #5 SCLK = ~SCLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Advance one cycle; inputs change 2 time units after the rising edge.
   // Capture pattern: Q0 = 2*(cyc-base), Q1 = 2*(cyc-base)+1.
   task automatic step();
      @(posedge SCLK);
      #2;
      cyc++;
      iddr_q0 = DQ'(2 * (cyc - base));
      iddr_q1 = DQ'(2 * (cyc - base) + 1);
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   function automatic logic [8*DQ-1:0] exp_word(input int rel);
      logic [8*DQ-1:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w[2*k*DQ +: DQ]     = DQ'(2 * (rel + k));
         w[(2*k+1)*DQ +: DQ] = DQ'(2 * (rel + k) + 1);
      end
      return w;
   endfunction

   task automatic expect_burst(input logic [8*DQ-1:0] d, input logic [TW-1:0] t);
      exp_d.push_back(d);
      exp_t.push_back(t);
   endtask

   // Pulse rd_issue for the current cycle, then release it.
   task automatic issue(input logic [TW-1:0] t);
      rd_issue = 1'b1;
      rd_tag   = t;
      step();
      rd_issue = 1'b0;
   endtask

   // Monitor: a transfer happens on the next rising edge when valid & ready.
   initial begin
      logic [8*DQ-1:0] ed;
      logic [TW-1:0]   et;
      forever begin
         @(negedge SCLK);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_d.size() == 0) begin
               $display("FAIL unexpected_word: got tag %0h data %h, required no word", out_tag, out_data);
            end else begin
               ed = exp_d.pop_front();
               et = exp_t.pop_front();
               if (out_data === ed && out_tag === et) passed++;
               else $display("FAIL burst_word: got tag %0h data %h, required tag %0h data %h",
                             out_tag, out_data, et, ed);
            end
         end
      end
   end

   initial begin
      RST       = 1'b1;
      rd_issue  = 1'b0;
      rd_tag    = '0;
      cfg_rl    = RLW'(5);
      out_ready = 1'b1;
      iddr_q0   = '0;
      iddr_q1   = '0;
`ifdef RD_LAT_CAL_EN
      cal_start = 1'b0;
`endif

      // Reset state and iddr_rst release window
      steps(3);
      check("rst_iddr_rst", 32'(iddr_rst), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      RST      = 1'b0;
      rd_issue = 1'b1;
      rd_tag   = 4'hF;
      check("rel0_iddr_rst", 32'(iddr_rst), 32'd1);
      step();
      check("rel1_iddr_rst", 32'(iddr_rst), 32'd1);
      step();
      rd_issue = 1'b0;
      check("rel2_iddr_rst", 32'(iddr_rst), 32'd0);
      check("rel2_busy", 32'(busy), 32'd0);
      steps(10);
      check("rel_ignored_busy", 32'(busy), 32'd0);

      // Single burst, RL=5, beats 0..7, tag 3
      n    = cyc;
      base = n + 5;
      expect_burst(128'h0007_0006_0005_0004_0003_0002_0001_0000, 4'd3);
      issue(4'd3);
      check("t1_busy", 32'(busy), 32'd1);
      steps(7);
      check("t1_valid_t8", 32'(out_valid), 32'd0);
      step();
      check("t1_valid_t9", 32'(out_valid), 32'd1);
      check("t1_tag_t9", 32'(out_tag), 32'd3);
      steps(40);

      // Back-to-back bursts 4 cycles apart
      n = cyc;
      expect_burst(exp_word(n + 5 - base), 4'd1);
      issue(4'd1);
      steps(3);
      expect_burst(exp_word(n + 9 - base), 4'd2);
      issue(4'd2);
      steps(4);
      check("t2_valid_t9", 32'(out_valid), 32'd1);
      check("t2_tag_t9", 32'(out_tag), 32'd1);
      steps(4);
      check("t2_valid_t13", 32'(out_valid), 32'd1);
      check("t2_tag_t13", 32'(out_tag), 32'd2);
      steps(40);
      check("t2_err", 32'(err), 32'd0);

      // Issues 2 cycles apart: second collides and is dropped
      n = cyc;
      expect_burst(exp_word(n + 5 - base), 4'd4);
      issue(4'd4);
      step();
      issue(4'd5);
      steps(40);
      check("t3_err", 32'(err), 32'b010);
      check("t3_busy_idle", 32'(busy), 32'd0);

      // Output buffer overflow: three completions with out_ready low
      out_ready = 1'b0;
      n = cyc;
      expect_burst(exp_word(n + 5 - base), 4'd6);
      issue(4'd6);
      steps(3);
      expect_burst(exp_word(n + 9 - base), 4'd7);
      issue(4'd7);
      steps(3);
      issue(4'd8);
      steps(9);
      check("t4_err", 32'(err), 32'b110);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      check("t4_head_tag", 32'(out_tag), 32'd6);
      out_ready = 1'b1;
      steps(40);

      // Tag FIFO overflow with RL=31: QDEPTH+1 issues, QDEPTH bursts
      cfg_rl = RLW'(31);
      n = cyc;
      for (int i = 0; i < QD + 1; i++) begin
         if (i < QD) expect_burst(exp_word(n + 4*i + 31 - base), TW'(9 + i));
         issue(TW'(9 + i));
         if (i < QD) steps(3);
      end
      check("t5_err", 32'(err), 32'b111);
      check("t5_busy", 32'(busy), 32'd1);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 200 && exp_d.size() != 0; i++) step();
      steps(40);
      check("drain_queue_empty", 32'(exp_d.size()), 32'd0);
      check("final_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
